// File: rtl/count_bcd_display_pkg.sv
// Shared definitions for the BCD display path: segment patterns,
// converter state encoding and parameter-legality helper.
package count_bcd_display_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } conv_state_t;

   // Smallest digit count d with 10^d > 2^bin_w (valid for bin_w up to 63).
   function automatic int min_digits(input int bin_w);
      logic [63:0] p2;
      logic [63:0] p10;
      int          d;
      p2  = 64'd1 << bin_w;
      p10 = 64'd1;
      d   = 0;
      for (int i = 0; i < 19; i++) begin
         if (p10 <= p2) begin
            p10 = p10 * 64'd10;
            d   = d + 1;
         end
      end
      return d;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/count_bcd_display_if.sv
// Bundle between the counter side and the display block.
// Handshake: load is sampled only while the converter is idle (busy=0 and no
// result pending); bcd_valid is a one-cycle pulse marking a new bcd_out.
interface count_bcd_display_if #(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 4
);
   import count_bcd_display_pkg::*;

   logic [BIN_W-1:0]    bin_in;
   logic                load;
   logic                busy;
   logic [4*DIGITS-1:0] bcd_out;
   logic                bcd_valid;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   dig_sel;
   conv_state_t         conv_state;

   modport master (
      output bin_in, load,
      input  busy, bcd_out, bcd_valid, seg, dig_sel, conv_state
   );

   modport slave (
      input  bin_in, load,
      output busy, bcd_out, bcd_valid, seg, dig_sel, conv_state
   );

endinterface

// File: rtl/count_bcd_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock,
// result published in the cycle after the last shift.
module bin2bcd_seq
   import count_bcd_display_pkg::*;
#(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BIN_W-1:0]    bin_in,
   input  logic                load,
   output logic                busy,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic                bcd_valid,
   output conv_state_t         state
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   conv_state_t          state_q;
   conv_state_t          state_d;
   logic [BIN_W-1:0]     shift_q;
   logic [BCD_W-1:0]     scratch_q;
   logic [BCD_W-1:0]     scratch_adj;
   logic [BCD_W+BIN_W-1:0] pair_shl;
   logic [CNT_W-1:0]     bit_cnt_q;
   logic [BCD_W-1:0]     bcd_q;
   logic                 valid_q;

   // Nibble add-3 cannot carry out: a nibble is at most 9 before adjusting.
   always_comb begin
      scratch_adj = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5)
            scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
   end

   assign pair_shl = {scratch_adj, shift_q} << 1;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      case (state_q)
         ST_IDLE:  if (load) state_d = ST_SHIFT;
         ST_SHIFT: begin
            busy = 1'b1;
            if (bit_cnt_q == CNT_W'(1)) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q   <= '0;
         scratch_q <= '0;
         bit_cnt_q <= '0;
         bcd_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (load) begin
                  shift_q   <= bin_in;
                  scratch_q <= '0;
                  bit_cnt_q <= CNT_W'(BIN_W);
               end
            end
            ST_SHIFT: begin
               {scratch_q, shift_q} <= pair_shl;
               bit_cnt_q            <= bit_cnt_q - CNT_W'(1);
            end
            ST_DONE: begin
               bcd_q   <= scratch_q;
               valid_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bcd_out   = bcd_q;
   assign bcd_valid = valid_q;
   assign state     = state_q;

endmodule

// File: rtl/count_bcd_display.sv
// Display block: converts the binary count to BCD and scans it onto a
// time-multiplexed active-high 7-segment display.
module count_bcd_display
   import count_bcd_display_pkg::*;
#(
   parameter int BIN_W    = 10,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1024
) (
   input logic                clk,
   input logic                rst,
   count_bcd_display_if.slave bus
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
      $error("count_bcd_display: DIGITS too small to hold 2^BIN_W-1");
   end
   if (SCAN_DIV < 2) begin : g_scan_check
      $error("count_bcd_display: SCAN_DIV must be at least 2");
   end

   logic [4*DIGITS-1:0] bcd_int;
   logic                busy_int;
   logic                valid_int;
   conv_state_t         state_int;

   bin2bcd_seq #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk       (clk),
      .rst       (rst),
      .bin_in    (bus.bin_in),
      .load      (bus.load),
      .busy      (busy_int),
      .bcd_out   (bcd_int),
      .bcd_valid (valid_int),
      .state     (state_int)
   );

   logic [SCAN_W-1:0] scan_q;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  idx_d;
   logic [6:0]        seg_q;
   logic [DIGITS-1:0] dig_sel_c;
   logic              wrap;

   assign wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));

   always_comb begin
      idx_d = idx_q;
      if (wrap) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
   end

   // seg is decoded from the index taking effect on this edge so it
   // switches together with dig_sel.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q <= '0;
         idx_q  <= '0;
         seg_q  <= SEG_0;
      end else begin
         scan_q <= wrap ? '0 : scan_q + SCAN_W'(1);
         idx_q  <= idx_d;
         seg_q  <= seg_decode(bcd_int[4*idx_d +: 4]);
      end
   end

   always_comb begin
      dig_sel_c        = '0;
      dig_sel_c[idx_q] = 1'b1;
   end

   assign bus.busy       = busy_int;
   assign bus.bcd_out    = bcd_int;
   assign bus.bcd_valid  = valid_int;
   assign bus.seg        = seg_q;
   assign bus.dig_sel    = dig_sel_c;
   assign bus.conv_state = state_int;

endmodule
